// File: rtl/spi_txn_pkg.sv
// Shared definitions for the USB-SPI register access protocol (initiator and responder).
// Command codes, frame slot layout and the initiator FSM state encoding.
package spi_txn_pkg;

  localparam logic [7:0] CMMD_GET  = 8'd5;
  localparam logic [7:0] CMMD_PUT  = 8'd6;

  localparam logic [3:0] SLOT_PAD  = 4'd1;
  localparam logic [3:0] SLOT_ADDR = 4'd2;
  localparam logic [3:0] SLOT_DATA = 4'd6;
  localparam logic [3:0] PUT_LEN   = 4'd10;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    TX,
    RX,
    GAP
  } txn_state_e;

endpackage

// File: rtl/spi_txn_byte_mux.sv
// Slot-index to outgoing-byte selector for one GET/PUT frame.
module spi_txn_byte_mux
  import spi_txn_pkg::*;
(
  input  logic [3:0]  idx,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [7:0]  byte_o
);

  // GET data slots (and any read-skip slots) send zero filler.
  always_comb begin
    byte_o = 8'h00;
    case (idx)
      4'd0:             byte_o = wr ? CMMD_PUT : CMMD_GET;
      SLOT_PAD:         byte_o = 8'h00;
      SLOT_ADDR:        byte_o = addr[7:0];
      SLOT_ADDR + 4'd1: byte_o = addr[15:8];
      SLOT_ADDR + 4'd2: byte_o = addr[23:16];
      SLOT_ADDR + 4'd3: byte_o = addr[31:24];
      SLOT_DATA:        byte_o = wr ? wr_data[7:0]   : 8'h00;
      SLOT_DATA + 4'd1: byte_o = wr ? wr_data[15:8]  : 8'h00;
      SLOT_DATA + 4'd2: byte_o = wr ? wr_data[23:16] : 8'h00;
      SLOT_DATA + 4'd3: byte_o = wr ? wr_data[31:24] : 8'h00;
      default:          byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/spi_txn_master.sv
// Initiator for the USB-SPI register protocol: one request -> one chip-select framed byte stream.
// Optional per-byte watchdog enabled by defining SPI_TXN_TIMEOUT_EN.
module spi_txn_master
  import spi_txn_pkg::*;
#(
  parameter int RD_SKIP     = 0,
  parameter int LEAD_CYC    = 2,
  parameter int CS_GAP      = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        up_clk,
  input  logic        up_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wr_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_rd_data,
  output logic        rsp_err,
  output logic        spi_cs,
  output logic        spi_byte_o_en,
  output logic [7:0]  spi_byte_o,
  input  logic        spi_byte_o_ready,
  input  logic        spi_byte_i_en,
  input  logic [7:0]  spi_byte_i
);

  // One counter width covers lead, gap and watchdog intervals.
  localparam int CNT_MAX = (TIMEOUT_CYC > CS_GAP)
                         ? ((TIMEOUT_CYC > LEAD_CYC) ? TIMEOUT_CYC : LEAD_CYC)
                         : ((CS_GAP > LEAD_CYC) ? CS_GAP : LEAD_CYC);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LEAD_LOAD = CNT_W'((LEAD_CYC > 0) ? LEAD_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((CS_GAP > 1) ? CS_GAP - 1 : 0);
  localparam logic [3:0]       GET_LEN   = 4'(PUT_LEN + RD_SKIP);
  localparam logic [3:0]       RD_FIRST  = 4'(SLOT_DATA + RD_SKIP);
  localparam logic [3:0]       RD_LAST   = 4'(SLOT_DATA + RD_SKIP + 3);

  txn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic             wr_q, wr_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             byte_done;
  logic [3:0]       frame_len;
  logic             rd_slot;
  logic [7:0]       mux_byte;

`ifdef SPI_TXN_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  spi_txn_byte_mux u_byte_mux (
    .idx     (idx_q),
    .wr      (wr_q),
    .addr    (addr_q),
    .wr_data (wdata_q),
    .byte_o  (mux_byte)
  );

  assign frame_len = wr_q ? PUT_LEN : GET_LEN;
  assign rd_slot   = !wr_q && (idx_q >= RD_FIRST) && (idx_q <= RD_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    byte_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          addr_d  = req_addr;
          wdata_d = req_wr_data;
          rdata_d = 32'h0;
          idx_d   = 4'd0;
          cnt_d   = LEAD_LOAD;
          state_d = LEAD;
        end
      end
      LEAD: begin
        if (cnt_q == '0) state_d = TX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      TX: begin
        // An echo arriving together with the accept closes the slot without visiting RX.
        if (spi_byte_o_ready) begin
          if (spi_byte_i_en) byte_done = 1'b1;
          else               state_d   = RX;
        end
      end
      RX: begin
        if (spi_byte_i_en) byte_done = 1'b1;
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = GAP;
    endcase

    if (byte_done) begin
      if (rd_slot) rdata_d = {rdata_q[23:0], spi_byte_i};
      idx_d = idx_q + 4'd1;
      if (idx_q + 4'd1 == frame_len) begin
        state_d     = GAP;
        cnt_d       = GAP_LOAD;
        rsp_valid_d = 1'b1;
      end else begin
        state_d = TX;
      end
    end

`ifdef SPI_TXN_TIMEOUT_EN
    wdog_d    = '0;
    rsp_err_d = 1'b0;
    if ((state_q == TX || state_q == RX) && !byte_done) begin
      if (wdog_q == WDOG_LAST) begin
        state_d     = GAP;
        cnt_d       = GAP_LOAD;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rdata_d     = 32'h0;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
`endif
  end

  // Reset lands in GAP so the responder sees a full idle gap before the first frame.
  always_ff @(posedge up_clk or negedge up_rst_n) begin
    if (!up_rst_n) begin
      state_q     <= GAP;
      cnt_q       <= GAP_LOAD;
      idx_q       <= 4'd0;
      wr_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef SPI_TXN_TIMEOUT_EN
  always_ff @(posedge up_clk or negedge up_rst_n) begin
    if (!up_rst_n) begin
      wdog_q    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Chip select drops in the accepting cycle so back-to-back frames see exactly CS_GAP high cycles.
  always_comb begin
    case (state_q)
      LEAD, TX, RX: spi_cs = 1'b0;
      IDLE:         spi_cs = ~req_valid;
      default:      spi_cs = 1'b1;
    endcase
  end

  assign req_ready     = (state_q == IDLE);
  assign spi_byte_o_en = (state_q == TX);
  assign spi_byte_o    = (state_q == TX) ? mux_byte : 8'h00;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rd_data   = rdata_q;

endmodule

// File: tb/tb_spi_txn_master.sv
// Directed bench for spi_txn_master: PUT/GET frames, read skip with stalls, back-to-back, reset, watchdog.
module tb_spi_txn_master;

  logic        up_clk = 1'b0;
  logic        up_rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wr_data = 32'h0;
  logic        shf_ready = 1'b0;
  logic        shf_i_en = 1'b0;
  logic [7:0]  shf_i = 8'h00;
  logic        sel = 1'b0;

  logic        req_ready_a, rsp_valid_a, rsp_err_a, cs_a, en_a;
  logic [31:0] rd_a;
  logic [7:0]  byte_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b, cs_b, en_b;
  logic [31:0] rd_b;
  logic [7:0]  byte_b;

  logic        req_ready_s, rsp_valid_s, rsp_err_s, cs_s, en_s;
  logic [31:0] rd_s;
  logic [7:0]  byte_s;

  int          vec = 0;
  int          miss = 0;
  int          cyc = 0;
  int          n_rsp = 0;
  int          last_rsp_cyc = 0;
  logic [31:0] got_rd = 32'h0;
  logic        got_err = 1'b0;

  logic [7:0]  tx_log [0:15];
  logic [7:0]  rsp_bytes [0:15];
  int          cs_hi_cnt, stall_bad, hang, lead_wait;

  always #5 up_clk = ~up_clk;

  spi_txn_master #(.RD_SKIP(0), .LEAD_CYC(2), .CS_GAP(4), .TIMEOUT_CYC(16)) u_dut_a (
    .up_clk(up_clk), .up_rst_n(up_rst_n),
    .req_valid(req_valid & ~sel), .req_ready(req_ready_a), .req_wr(req_wr),
    .req_addr(req_addr), .req_wr_data(req_wr_data),
    .rsp_valid(rsp_valid_a), .rsp_rd_data(rd_a), .rsp_err(rsp_err_a),
    .spi_cs(cs_a), .spi_byte_o_en(en_a), .spi_byte_o(byte_a),
    .spi_byte_o_ready(shf_ready & ~sel), .spi_byte_i_en(shf_i_en & ~sel), .spi_byte_i(shf_i)
  );

  spi_txn_master #(.RD_SKIP(1), .LEAD_CYC(2), .CS_GAP(4), .TIMEOUT_CYC(16)) u_dut_b (
    .up_clk(up_clk), .up_rst_n(up_rst_n),
    .req_valid(req_valid & sel), .req_ready(req_ready_b), .req_wr(req_wr),
    .req_addr(req_addr), .req_wr_data(req_wr_data),
    .rsp_valid(rsp_valid_b), .rsp_rd_data(rd_b), .rsp_err(rsp_err_b),
    .spi_cs(cs_b), .spi_byte_o_en(en_b), .spi_byte_o(byte_b),
    .spi_byte_o_ready(shf_ready & sel), .spi_byte_i_en(shf_i_en & sel), .spi_byte_i(shf_i)
  );

  assign req_ready_s = sel ? req_ready_b : req_ready_a;
  assign rsp_valid_s = sel ? rsp_valid_b : rsp_valid_a;
  assign rsp_err_s   = sel ? rsp_err_b   : rsp_err_a;
  assign cs_s        = sel ? cs_b        : cs_a;
  assign en_s        = sel ? en_b        : en_a;
  assign rd_s        = sel ? rd_b        : rd_a;
  assign byte_s      = sel ? byte_b      : byte_a;

  always @(posedge up_clk) cyc <= cyc + 1;

  always @(negedge up_clk) begin
    if (rsp_valid_s) begin
      n_rsp        <= n_rsp + 1;
      got_rd       <= rd_s;
      got_err      <= rsp_err_s;
      last_rsp_cyc <= cyc;
    end
  end

  // Shifter/responder model: records outgoing bytes and returns rsp_bytes[slot] per slot.
  task automatic run_frame(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input int nslots, input int stall, input int echo_dly,
                           input bit keep_valid, input int stop_slot);
    int n;
    cs_hi_cnt = 0; stall_bad = 0; hang = 0; lead_wait = 0;
    req_wr = wr; req_addr = addr; req_wr_data = data; req_valid = 1'b1;
    n = 0;
    while (!req_ready_s && n < 100) begin @(negedge up_clk); n++; end
    if (!req_ready_s) begin hang++; req_valid = 1'b0; return; end
    @(negedge up_clk);
    if (!keep_valid) req_valid = 1'b0;
    for (int s = 0; s < nslots; s++) begin
      n = 0;
      while (!en_s && n < 100) begin
        if (cs_s) cs_hi_cnt++;
        @(negedge up_clk); n++;
      end
      if (!en_s) begin hang++; return; end
      if (s == 0) lead_wait = n;
      if (cs_s) cs_hi_cnt++;
      tx_log[s] = byte_s;
      if (s == stop_slot) return;
      for (int k = 0; k < stall; k++) begin
        @(negedge up_clk);
        if (!en_s || byte_s !== tx_log[s]) stall_bad++;
      end
      shf_ready = 1'b1;
      if (echo_dly == 0) begin shf_i_en = 1'b1; shf_i = rsp_bytes[s]; end
      @(negedge up_clk);
      shf_ready = 1'b0; shf_i_en = 1'b0;
      if (echo_dly > 0) begin
        for (int k = 0; k < echo_dly - 1; k++) begin
          if (cs_s) cs_hi_cnt++;
          @(negedge up_clk);
        end
        if (cs_s) cs_hi_cnt++;
        shf_i_en = 1'b1; shf_i = rsp_bytes[s];
        @(negedge up_clk);
        shf_i_en = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    up_rst_n = 1'b0;
    repeat (2) @(negedge up_clk);
    #1;
    vec++; if (cs_a !== 1'b1)       begin miss++; $display("FAIL reset_cs got %b exp 1", cs_a); end
    vec++; if (en_a !== 1'b0)       begin miss++; $display("FAIL reset_byte_o_en got %b exp 0", en_a); end
    vec++; if (byte_a !== 8'h00)    begin miss++; $display("FAIL reset_byte_o got %h exp 00", byte_a); end
    vec++; if (req_ready_a !== 1'b0) begin miss++; $display("FAIL reset_req_ready got %b exp 0", req_ready_a); end
    vec++; if (rsp_valid_a !== 1'b0) begin miss++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid_a); end
    vec++; if (rd_a !== 32'h0)      begin miss++; $display("FAIL reset_rd_data got %h exp 0", rd_a); end
    vec++; if (rsp_err_a !== 1'b0)  begin miss++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err_a); end
    @(negedge up_clk);
    up_rst_n = 1'b1;
    n = 0;
    do begin @(negedge up_clk); n++; end while (!req_ready_a && n < 50);
    vec++; if (n !== 4) begin miss++; $display("FAIL reset_to_ready got %0d cycles exp 4", n); end
    $display("reset: first req_ready after %0d cycles", n);
  endtask

  task automatic test_put();
    logic [7:0] exp_b [0:9];
    int n0;
    exp_b = '{8'h06, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    for (int i = 0; i < 16; i++) rsp_bytes[i] = 8'h5A;
    n0 = n_rsp;
    run_frame(1'b1, 32'h1234_5678, 32'hCAFE_F00D, 10, 0, 3, 1'b0, -1);
    repeat (6) @(negedge up_clk);
    for (int i = 0; i < 10; i++) begin
      vec++; if (tx_log[i] !== exp_b[i]) begin miss++; $display("FAIL put_byte%0d got %h exp %h", i, tx_log[i], exp_b[i]); end
    end
    vec++; if (hang !== 0)      begin miss++; $display("FAIL put_hang got %0d exp 0", hang); end
    vec++; if (lead_wait !== 2) begin miss++; $display("FAIL put_lead got %0d exp 2", lead_wait); end
    vec++; if (cs_hi_cnt !== 0) begin miss++; $display("FAIL put_cs_low got %0d high samples exp 0", cs_hi_cnt); end
    vec++; if (n_rsp - n0 !== 1) begin miss++; $display("FAIL put_rsp_count got %0d exp 1", n_rsp - n0); end
    vec++; if (got_err !== 1'b0) begin miss++; $display("FAIL put_err got %b exp 0", got_err); end
    vec++; if (got_rd !== 32'h0) begin miss++; $display("FAIL put_rd_data got %h exp 0", got_rd); end
    vec++; if (en_a !== 1'b0 || cs_a !== 1'b1) begin miss++; $display("FAIL put_after en=%b cs=%b exp 0 1", en_a, cs_a); end
    $display("put addr=12345678 data=cafef00d rsp_count=%0d err=%b", n_rsp - n0, got_err);
  endtask

  task automatic test_get();
    logic [7:0] exp_b [0:9];
    logic [7:0] rd_b4 [0:3];
    int n0;
    exp_b = '{8'h05, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rd_b4 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < 16; i++) rsp_bytes[i] = 8'hA5;
    for (int i = 0; i < 4; i++) rsp_bytes[6 + i] = rd_b4[i];
    n0 = n_rsp;
    run_frame(1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 10, 1, 1, 1'b0, -1);
    repeat (6) @(negedge up_clk);
    for (int i = 0; i < 10; i++) begin
      vec++; if (tx_log[i] !== exp_b[i]) begin miss++; $display("FAIL get_byte%0d got %h exp %h", i, tx_log[i], exp_b[i]); end
    end
    vec++; if (n_rsp - n0 !== 1) begin miss++; $display("FAIL get_rsp_count got %0d exp 1", n_rsp - n0); end
    vec++; if (got_rd !== 32'hDEAD_BEEF) begin miss++; $display("FAIL get_rd_data got %h exp deadbeef", got_rd); end
    vec++; if (got_err !== 1'b0) begin miss++; $display("FAIL get_err got %b exp 0", got_err); end
    $display("get addr=00000010 rd_data=%h", got_rd);
  endtask

  task automatic test_get_skip_stall();
    logic [7:0] exp_b [0:10];
    int n0;
    exp_b = '{8'h05, 8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) rsp_bytes[i] = 8'h77;
    rsp_bytes[6] = 8'h99; rsp_bytes[7] = 8'h11; rsp_bytes[8] = 8'h22;
    rsp_bytes[9] = 8'h33; rsp_bytes[10] = 8'h44;
    sel = 1'b1;
    @(negedge up_clk);
    n0 = n_rsp;
    run_frame(1'b0, 32'hA1B2_C3D4, 32'h0, 11, 5, 0, 1'b0, -1);
    repeat (6) @(negedge up_clk);
    for (int i = 0; i < 11; i++) begin
      vec++; if (tx_log[i] !== exp_b[i]) begin miss++; $display("FAIL skip_byte%0d got %h exp %h", i, tx_log[i], exp_b[i]); end
    end
    vec++; if (stall_bad !== 0) begin miss++; $display("FAIL skip_stall_stable got %0d unstable samples exp 0", stall_bad); end
    vec++; if (n_rsp - n0 !== 1) begin miss++; $display("FAIL skip_rsp_count got %0d exp 1", n_rsp - n0); end
    vec++; if (got_rd !== 32'h1122_3344) begin miss++; $display("FAIL skip_rd_data got %h exp 11223344", got_rd); end
    vec++; if (en_b !== 1'b0) begin miss++; $display("FAIL skip_extra_slot en got %b exp 0", en_b); end
    $display("get rd_skip=1 addr=a1b2c3d4 rd_data=%h", got_rd);
    sel = 1'b0;
    @(negedge up_clk);
  endtask

  task automatic test_back_to_back();
    int hi, n, n0, rdy_cyc;
    for (int i = 0; i < 16; i++) rsp_bytes[i] = 8'h00;
    rsp_bytes[6] = 8'h01; rsp_bytes[7] = 8'h02; rsp_bytes[8] = 8'h03; rsp_bytes[9] = 8'h04;
    n0 = n_rsp;
    run_frame(1'b1, 32'h0000_0020, 32'h0000_00FF, 10, 0, 1, 1'b1, -1);
    hi = 0; n = 0;
    while (cs_a && n < 100) begin hi++; @(negedge up_clk); n++; end
    rdy_cyc = cyc;
    vec++; if (hi !== 4) begin miss++; $display("FAIL b2b_cs_gap got %0d exp 4", hi); end
    vec++; if (req_ready_a !== 1'b1) begin miss++; $display("FAIL b2b_ready got %b exp 1", req_ready_a); end
    vec++; if (rdy_cyc - last_rsp_cyc !== 4) begin miss++; $display("FAIL b2b_rsp_to_ready got %0d exp 4", rdy_cyc - last_rsp_cyc); end
    run_frame(1'b0, 32'h0000_0030, 32'h0, 10, 0, 1, 1'b0, -1);
    repeat (6) @(negedge up_clk);
    vec++; if (tx_log[2] !== 8'h30) begin miss++; $display("FAIL b2b_addr_byte got %h exp 30", tx_log[2]); end
    vec++; if (n_rsp - n0 !== 2) begin miss++; $display("FAIL b2b_rsp_count got %0d exp 2", n_rsp - n0); end
    vec++; if (got_rd !== 32'h0102_0304) begin miss++; $display("FAIL b2b_rd_data got %h exp 01020304", got_rd); end
    $display("back_to_back gap=%0d rd_data=%h", hi, got_rd);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] exp_b [0:9];
    int n0;
    for (int i = 0; i < 16; i++) rsp_bytes[i] = 8'h3C;
    run_frame(1'b1, 32'h0BAD_F00D, 32'h1122_3344, 10, 0, 1, 1'b0, 4);
    vec++; if (tx_log[4] !== 8'hAD) begin miss++; $display("FAIL rst_slot4 got %h exp ad", tx_log[4]); end
    n0 = n_rsp;
    up_rst_n = 1'b0;
    #1;
    vec++; if (cs_a !== 1'b1) begin miss++; $display("FAIL rst_cs got %b exp 1", cs_a); end
    vec++; if (en_a !== 1'b0) begin miss++; $display("FAIL rst_byte_o_en got %b exp 0", en_a); end
    repeat (2) @(negedge up_clk);
    up_rst_n = 1'b1;
    repeat (15) @(negedge up_clk);
    vec++; if (n_rsp !== n0) begin miss++; $display("FAIL rst_no_rsp got %0d exp 0", n_rsp - n0); end
    exp_b = '{8'h06, 8'h00, 8'h0D, 8'hF0, 8'hAD, 8'h0B, 8'h44, 8'h33, 8'h22, 8'h11};
    run_frame(1'b1, 32'h0BAD_F00D, 32'h1122_3344, 10, 0, 2, 1'b0, -1);
    repeat (6) @(negedge up_clk);
    for (int i = 0; i < 10; i++) begin
      vec++; if (tx_log[i] !== exp_b[i]) begin miss++; $display("FAIL rst_clean_byte%0d got %h exp %h", i, tx_log[i], exp_b[i]); end
    end
    vec++; if (n_rsp - n0 !== 1) begin miss++; $display("FAIL rst_clean_rsp got %0d exp 1", n_rsp - n0); end
    $display("reset mid-frame then clean put rsp_count=%0d", n_rsp - n0);
  endtask

`ifdef SPI_TXN_TIMEOUT_EN
  task automatic test_timeout();
    int c, n;
    run_frame(1'b0, 32'h0000_0044, 32'h0, 10, 0, 0, 1'b0, 0);
    c = 0; n = 0;
    do begin
      if (en_a) c++;
      @(negedge up_clk); n++;
    end while (!rsp_valid_a && n < 100);
    vec++; if (c !== 16) begin miss++; $display("FAIL tmo_tx_cycles got %0d exp 16", c); end
    vec++; if (rsp_valid_a !== 1'b1) begin miss++; $display("FAIL tmo_rsp_valid got %b exp 1", rsp_valid_a); end
    vec++; if (rsp_err_a !== 1'b1) begin miss++; $display("FAIL tmo_err got %b exp 1", rsp_err_a); end
    vec++; if (rd_a !== 32'h0) begin miss++; $display("FAIL tmo_rd_data got %h exp 0", rd_a); end
    vec++; if (cs_a !== 1'b1 || en_a !== 1'b0) begin miss++; $display("FAIL tmo_idle cs=%b en=%b exp 1 0", cs_a, en_a); end
    $display("timeout after %0d tx cycles err=%b", c, rsp_err_a);
  endtask
`else
  task automatic test_timeout();
    int n0;
    n0 = n_rsp;
    run_frame(1'b0, 32'h0000_0044, 32'h0, 10, 0, 0, 1'b0, 0);
    repeat (40) @(negedge up_clk);
    vec++; if (en_a !== 1'b1) begin miss++; $display("FAIL nowdog_en got %b exp 1", en_a); end
    vec++; if (cs_a !== 1'b0) begin miss++; $display("FAIL nowdog_cs got %b exp 0", cs_a); end
    vec++; if (n_rsp !== n0) begin miss++; $display("FAIL nowdog_rsp got %0d exp 0", n_rsp - n0); end
    vec++; if (rsp_err_a !== 1'b0) begin miss++; $display("FAIL nowdog_err got %b exp 0", rsp_err_a); end
    $display("no watchdog: still waiting in TX after 40 cycles");
    up_rst_n = 1'b0;
    repeat (2) @(negedge up_clk);
    up_rst_n = 1'b1;
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) begin tx_log[i] = 8'h00; rsp_bytes[i] = 8'h00; end
    test_reset();
    test_put();
    test_get();
    test_get_skip_stall();
    test_back_to_back();
    test_reset_midframe();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got stuck exp finish");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/spi_txn_master.md
Name: spi_txn_master

Overview:
- Initiator side of the USB-SPI register access protocol. Drives GET/PUT frames toward the SPI responder FSM.
- Accepts one register request at a time on an up-style request port. Serialises it into command, pad, address and data bytes for a byte-level SPI shift engine.
- For GET, reassembles the returned read bytes into a 32-bit word.
- Sits between a host/bench controller and the SPI byte shifter, all in the up_clk domain.

Parameters:
- CMMD_GET, 8'd5, command byte for a read.
- CMMD_PUT, 8'd6, command byte for a write.
- RD_SKIP, 0, dummy byte slots between the last address byte and the first read-data slot (0..3).
- LEAD_CYC, 2, up_clk cycles spi_cs is held low before the first byte.
- CS_GAP, 4, up_clk cycles spi_cs is held high after a frame before the next request is accepted (minimum 1).
- TIMEOUT_CYC, 1024, per-byte watchdog limit (used only with the optional feature).

Ports:
- up_clk  in  1  sole clock.
- up_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when valid&ready.
- req_wr  in  1  1=PUT, 0=GET.
- req_addr  in  32  register address.
- req_wr_data  in  32  PUT data.
- rsp_valid  out  1  one-cycle pulse: frame finished.
- rsp_rd_data  out  32  GET result, valid with rsp_valid.
- rsp_err  out  1  abort flag, valid with rsp_valid.
- spi_cs  out  1  chip select, active low; high = idle/reset responder.
- spi_byte_o_en  out  1  byte to shifter valid.
- spi_byte_o  out  8  byte to shift out.
- spi_byte_o_ready  in  1  shifter accepted spi_byte_o.
- spi_byte_i_en  in  1  one-cycle pulse: one byte exchanged.
- spi_byte_i  in  8  byte received in that exchange.

Behaviour:
- Reset values: spi_cs=1, spi_byte_o_en=0, spi_byte_o=0, req_ready=0, rsp_valid=0, rsp_rd_data=0, rsp_err=0. The FSM enters GAP with the counter loaded, so the first request is accepted CS_GAP cycles after reset release.
- FSM states: IDLE, LEAD, TX, RX, GAP.
- IDLE
  - req_ready=1.
  - On req_valid: latch wr/addr/data, clear rx word and byte index, drive spi_cs=0, go to LEAD.
  - req_ready is 0 in every other state.
- LEAD: count LEAD_CYC cycles with spi_cs=0, then go to TX.
- TX
  - spi_byte_o_en=1; spi_byte_o is selected by the byte index (see byte map); both are held stable until spi_byte_o_ready.
  - On ready go to RX. If spi_byte_i_en arrives in the same cycle as ready, it is consumed and the FSM skips RX.
- RX
  - spi_byte_o_en=0; wait for spi_byte_i_en.
  - If the index is a read-data slot, shift spi_byte_i into rsp_rd_data MSB-first (first data byte ends up in [31:24]).
  - Increment the index. If the index equals the frame length, go to GAP and pulse rsp_valid; else go to TX.
- Byte map
  - Slot 0: command byte.
  - Slot 1: 8'h00 pad.
  - Slots 2..5: addr[7:0], [15:8], [23:16], [31:24].
  - PUT, slots 6..9: wr_data LSB-first. PUT frame length 10.
  - GET, slots 6..9+RD_SKIP: 8'h00. Read-data slots are 6+RD_SKIP..9+RD_SKIP. GET frame length 10+RD_SKIP.
- GAP
  - spi_cs=1 for CS_GAP cycles, then go to IDLE.
  - rsp_valid is asserted in the first GAP cycle only.
  - For PUT, rsp_rd_data holds 0.
- spi_byte_i_en outside RX/TX is ignored. spi_byte_o_ready outside TX is ignored.
- The byte index is 4 bits and never wraps; the frame length is at most 13.
- Asynchronous reset mid-frame: spi_cs goes high immediately, the frame is dropped, and no rsp_valid is produced.

Optional Feature:
- Macro: SPI_TXN_TIMEOUT_EN.
- Defined
  - A watchdog counter runs in TX and RX and restarts at each byte-slot transition.
  - On reaching TIMEOUT_CYC: drop spi_byte_o_en, go to GAP, pulse rsp_valid with rsp_err=1, and return rsp_rd_data=0.
- Undefined
  - No counter is built; the FSM waits indefinitely.
  - rsp_err is tied 0.

Decomposition:
- Shared package spi_txn_pkg:
  - command constants CMMD_GET/CMMD_PUT;
  - the FSM state enum;
  - frame slot constants: pad index 1, address base 2, data base 6, PUT length 10.
- The responder FSM uses the same command constants.
- One natural sub-module, spi_txn_byte_mux: combinational slot-index-to-byte selector.

Test Plan:
- PUT addr=32'h1234_5678, data=32'hCAFE_F00D, shifter ready same cycle, rx echo after 3 cycles -> bytes 06 00 78 56 34 12 0D F0 FE CA; spi_cs low across all 10 slots; one rsp_valid; rsp_err=0.
- GET addr=32'h0000_0010, RD_SKIP=0, responder returns slots 6..9 = DE AD BE EF -> tx 05 00 10 00 00 00 00 00 00 00; rsp_rd_data=32'hDEAD_BEEF.
- GET with RD_SKIP=1 and a 5-cycle ready stall per byte -> 11 slots sent; spi_byte_o held stable during each stall; data taken from slots 7..10.
- Back-to-back requests with req_valid held high -> spi_cs high for exactly CS_GAP cycles between frames; second req_ready pulse exactly CS_GAP cycles after the first rsp_valid.
- Assert up_rst_n low during slot 4 of a PUT -> spi_cs=1 and spi_byte_o_en=0 immediately; no rsp_valid; next request runs a full clean frame.
- With SPI_TXN_TIMEOUT_EN and TIMEOUT_CYC=16, spi_byte_o_ready never asserted -> rsp_valid with rsp_err=1 at cycle 16 of TX; spi_cs returns high.
